// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache: bus command, FSM state and line format.
package icache_pkg;

  localparam int unsigned ICACHE_LINES = 32;
  localparam int unsigned IDX_BITS     = $clog2(ICACHE_LINES);
  // Wide enough for the tag of any power-of-two line count; unused upper bits stay zero.
  localparam int unsigned LINE_TAG_BITS = 29;

  typedef enum logic [1:0] {
    BUS_NONE = 2'h0,
    BUS_LOAD = 2'h1
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    IC_IDLE = 2'h0,
    IC_REQ  = 2'h1,
    IC_WAIT = 2'h2
  } ICACHE_STATE;

  typedef struct packed {
    logic                     valid;
    logic [LINE_TAG_BITS-1:0] tag;
    logic [63:0]              data;
  } ICACHE_LINE;

  function automatic logic [31:0] block_align(logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: NumPorts combinational read ports, one write port,
// asynchronous clear of the valid bits only.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned NumLines = ICACHE_LINES
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NumPorts-1:0][$clog2(NumLines)-1:0] rd_idx_i,
  output ICACHE_LINE [NumPorts-1:0]                 rd_line_o,
  input  logic                                      wr_en_i,
  input  logic [$clog2(NumLines)-1:0]               wr_idx_i,
  input  ICACHE_LINE                                wr_line_i
);

  logic [NumLines-1:0]      valid_q, valid_d;
  logic [LINE_TAG_BITS-1:0] tag_q  [NumLines];
  logic [63:0]              data_q [NumLines];

  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_idx_i] = wr_line_i.valid;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  // Payload needs no reset: it is never observed while its valid bit is clear.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_line_i.tag;
      data_q[wr_idx_i] <= wr_line_i.data;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NumPorts; p++) begin
      rd_line_o[p].valid = valid_q[rd_idx_i[p]];
      rd_line_o[p].tag   = tag_q[rd_idx_i[p]];
      rd_line_o[p].data  = data_q[rd_idx_i[p]];
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with one outstanding refill over the tagged BUS_LOAD handshake.
// Define ICACHE_FILL_FWD_EN to forward fill data to matching ports in the fill cycle itself.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = 3,
  parameter int unsigned CACHE_LINES  = ICACHE_LINES,
  parameter int unsigned MEM_TAG_BITS = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [FETCH_WIDTH-1:0][31:0]  proc2Icache_addr,
  input  logic                          branch_flush_en,
  output logic [FETCH_WIDTH-1:0][63:0]  Icache_data,
  output logic [FETCH_WIDTH-1:0]        Icache_valid,
  output BUS_COMMAND                    proc2mem_command,
  output logic [31:0]                   proc2mem_addr,
  input  logic [MEM_TAG_BITS-1:0]       mem2proc_response,
  input  logic [63:0]                   mem2proc_data,
  input  logic [MEM_TAG_BITS-1:0]       mem2proc_tag
);

  localparam int unsigned IdxW = $clog2(CACHE_LINES);

  function automatic logic [LINE_TAG_BITS-1:0] tag_of(logic [31:0] addr);
    return addr[31:3] >> IdxW;
  endfunction

  ICACHE_STATE               state_q, state_d;
  logic [31:0]               miss_addr_q, miss_addr_d;
  logic [MEM_TAG_BITS-1:0]   pending_tag_q, pending_tag_d;

  logic [FETCH_WIDTH-1:0][IdxW-1:0] rd_idx;
  ICACHE_LINE [FETCH_WIDTH-1:0]     rd_line;
  logic [FETCH_WIDTH-1:0]           hit;
  logic                             any_miss;
  logic [28:0]                      sel_blk;
  logic                             fill_fire;
  ICACHE_LINE                       fill_line;
  logic                             addr_lo_unused;

  always_comb begin
    addr_lo_unused = 1'b0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      addr_lo_unused = addr_lo_unused ^ (^proc2Icache_addr[i][2:0]);
    end
  end

  // Lookup and lowest-index miss selection.
  always_comb begin
    any_miss = 1'b0;
    sel_blk  = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      rd_idx[i] = proc2Icache_addr[i][3 +: IdxW];
      hit[i]    = rd_line[i].valid && (rd_line[i].tag == tag_of(proc2Icache_addr[i]));
      if (!hit[i] && !any_miss) begin
        any_miss = 1'b1;
        sel_blk  = proc2Icache_addr[i][31:3];
      end
    end
  end

  assign fill_fire = (state_q == IC_WAIT) && (mem2proc_tag != '0) &&
                     (mem2proc_tag == pending_tag_q);

  always_comb begin
    fill_line.valid = 1'b1;
    fill_line.tag   = tag_of(miss_addr_q);
    fill_line.data  = mem2proc_data;
  end

  icache_line_array #(
    .NumPorts (FETCH_WIDTH),
    .NumLines (CACHE_LINES)
  ) u_lines (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .rd_idx_i  (rd_idx),
    .rd_line_o (rd_line),
    .wr_en_i   (fill_fire),
    .wr_idx_i  (miss_addr_q[3 +: IdxW]),
    .wr_line_i (fill_line)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IC_IDLE;
      miss_addr_q   <= '0;
      pending_tag_q <= '0;
    end else begin
      state_q       <= state_d;
      miss_addr_q   <= miss_addr_d;
      pending_tag_q <= pending_tag_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    pending_tag_d = pending_tag_q;
    unique case (state_q)
      IC_IDLE: begin
        if (any_miss && !branch_flush_en) begin
          miss_addr_d = block_align({sel_blk, 3'b000});
          state_d     = IC_REQ;
        end
      end
      IC_REQ: begin
        // An accepted request wins over a same-cycle flush.
        if (mem2proc_response != '0) begin
          pending_tag_d = mem2proc_response;
          state_d       = IC_WAIT;
        end else if (branch_flush_en) begin
          state_d = IC_IDLE;
        end
      end
      IC_WAIT: begin
        if (fill_fire) begin
          pending_tag_d = '0;
          state_d       = IC_IDLE;
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    if (state_q == IC_REQ) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = miss_addr_q;
    end
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      Icache_valid[i] = hit[i];
      Icache_data[i]  = hit[i] ? rd_line[i].data : 64'h0;
`ifdef ICACHE_FILL_FWD_EN
      if (fill_fire && (proc2Icache_addr[i][31:3] == miss_addr_q[31:3])) begin
        Icache_valid[i] = 1'b1;
        Icache_data[i]  = mem2proc_data;
      end
`else
`endif
    end
  end

endmodule
